spi_slave_responder: RTL

SPI mode-0 slave responder, the target-side counterpart of the SoC SPI masters (spi0/spi1). Oversamples SCK/CS/MOSI in the 50 MHz system domain, deserialises MOSI bytes, and serialises a one-deep transmit holding register onto MISO. Used as a behavioural or synthesizable peripheral endpoint on spi0/spi1 in place of a tied-high MISO.

---
 rtl/spi_slave_responder_if.sv | 42 ++++
 rtl/spi_slave_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder_if.sv
// ---------------------------------------------------------------------------
// spi_slave_responder_if
// Bundles the SPI pins and the local byte-side signals of the SPI slave
// responder.
//   SPI pins   : spi_clk, spi_cs, spi_mosi (towards responder), spi_miso (back)
//   TX side    : tx_data/tx_valid in, tx_ready out (one-deep holding register)
//   RX side    : rx_data/rx_valid out
//   Status     : tx_underrun, frame_start, frame_end, frame_abort, busy
// Handshake: a tx byte is transferred on a rising clock edge where both
// tx_valid and tx_ready are high; tx_valid may be raised at any time and
// tx_ready does not depend on tx_valid. rx_valid is a one-cycle pulse with
// no backpressure.
// Modports: slave = responder view, master = SoC/bench view.
// ---------------------------------------------------------------------------
interface spi_slave_responder_if;
   logic       spi_clk;
   logic       spi_cs;
   logic       spi_mosi;
   logic       spi_miso;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_underrun;
   logic       frame_start;
   logic       frame_end;
   logic       frame_abort;
   logic       busy;

   modport slave (
      input  spi_clk, spi_cs, spi_mosi, tx_data, tx_valid,
      output spi_miso, tx_ready, rx_data, rx_valid, tx_underrun,
             frame_start, frame_end, frame_abort, busy
   );

   modport master (
      output spi_clk, spi_cs, spi_mosi, tx_data, tx_valid,
      input  spi_miso, tx_ready, rx_data, rx_valid, tx_underrun,
             frame_start, frame_end, frame_abort, busy
   );
endinterface

// File: rtl/spi_slave_responder.sv
// ---------------------------------------------------------------------------
// spi_slave_responder
// SPI mode-0 slave responder. SCK/CS/MOSI are oversampled in the system
// clock domain; MOSI bytes are deserialised MSB-first and a one-deep transmit
// holding register is serialised onto MISO (DEFAULT_TX when empty).
// Ports:
//   ex_clk_50m : system clock, sole clock
//   rst_key    : synchronous active-low reset
//   bus        : spi_slave_responder_if.slave (pins, tx/rx byte side, status)
// The two-state frame FSM (IDLE/ACTIVE) is visible externally as bus.busy.
// ---------------------------------------------------------------------------
module spi_slave_responder #(
   parameter logic [7:0] DEFAULT_TX  = 8'hFF,
   parameter int         SYNC_STAGES = 2
) (
   input logic                  ex_clk_50m,
   input logic                  rst_key,
   spi_slave_responder_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   // synchronisers plus one history flop for edge detection
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   clk_hist;
   logic                   cs_hist;

   logic sck_s, cs_s, mosi_s;
   logic sck_rise, cs_fall, cs_rise;

   state_t state_q, state_d;

   logic [2:0] bit_cnt;
   logic [7:0] rx_shift;
   logic [7:0] rx_data_q;
   logic [7:0] tx_cur;
   logic [7:0] hold;
   logic       hold_full;
   logic [7:0] next_byte;

   logic rx_valid_q, tx_underrun_q, frame_start_q, frame_end_q, frame_abort_q;

   // strobes / outputs from the output decode
   logic start_evt, end_evt, bit_evt;
   logic miso_o, busy_o;

   // ---------------- input synchronisers ----------------
   always_ff @(posedge ex_clk_50m) begin
      if (!rst_key) begin
         clk_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '1;
         clk_hist  <= 1'b0;
         cs_hist   <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.spi_clk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
         clk_hist  <= clk_sync[SYNC_STAGES-1];
         cs_hist   <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = clk_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~clk_hist;
   assign cs_fall  = ~cs_s & cs_hist;
   assign cs_rise  = cs_s & ~cs_hist;

   assign next_byte = hold_full ? hold : DEFAULT_TX;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge ex_clk_50m) begin
      if (!rst_key) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = ACTIVE;
         ACTIVE:  if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      start_evt = 1'b0;
      end_evt   = 1'b0;
      bit_evt   = 1'b0;
      busy_o    = 1'b0;
      miso_o    = 1'b1;
      case (state_q)
         IDLE: begin
            start_evt = cs_fall;
         end
         ACTIVE: begin
            busy_o  = 1'b1;
            end_evt = cs_rise;
            // an SCK rise coinciding with the CS rise belongs to no byte
            bit_evt = sck_rise & ~cs_rise;
            // before a byte's first rise the upcoming byte's MSB is presented
            miso_o  = (bit_cnt == 3'd0) ? next_byte[7] : tx_cur[3'd7 - bit_cnt];
         end
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge ex_clk_50m) begin
      if (!rst_key) begin
         bit_cnt       <= 3'd0;
         rx_shift      <= 8'h00;
         rx_data_q     <= 8'h00;
         tx_cur        <= DEFAULT_TX;
         hold          <= 8'h00;
         hold_full     <= 1'b0;
         rx_valid_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         rx_valid_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         frame_start_q <= start_evt;
         frame_end_q   <= end_evt;
         frame_abort_q <= end_evt & (bit_cnt != 3'd0);

         if (start_evt || end_evt) begin
            bit_cnt <= 3'd0;
         end else if (bit_evt) begin
            bit_cnt  <= bit_cnt + 3'd1;
            rx_shift <= {rx_shift[6:0], mosi_s};
            if (bit_cnt == 3'd7) begin
               rx_data_q  <= {rx_shift[6:0], mosi_s};
               rx_valid_q <= 1'b1;
            end
            if (bit_cnt == 3'd0) begin
               tx_cur <= next_byte;
               if (!hold_full) tx_underrun_q <= 1'b1;
            end
         end

         // consume and write are exclusive: writes need an empty register
         if (bit_evt && (bit_cnt == 3'd0) && hold_full) begin
            hold_full <= 1'b0;
         end else if (bus.tx_valid && !hold_full) begin
            hold      <= bus.tx_data;
            hold_full <= 1'b1;
         end
      end
   end

   assign bus.spi_miso    = miso_o;
   assign bus.busy        = busy_o;
   assign bus.tx_ready    = ~hold_full;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_underrun = tx_underrun_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_end   = frame_end_q;
   assign bus.frame_abort = frame_abort_q;

endmodule
